// File: rtl/l2_cache_controller_pkg.sv
// Shared definitions for the direct-mapped instruction-side L2 controller:
// default geometry and FSM state encodings.
package l2_cache_controller_pkg;

  localparam int L1_TAG_W_DEF   = 54;
  localparam int L1_INDEX_W_DEF = 6;
  localparam int L2_INDEX_W_DEF = 8;
  localparam int L2_TAG_W_DEF   = L1_TAG_W_DEF + L1_INDEX_W_DEF - L2_INDEX_W_DEF;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE    = 3'd0;
  localparam state_t S_COMPARE = 3'd1;
  localparam state_t S_MEM_REQ = 3'd2;
  localparam state_t S_REFILL  = 3'd3;
  localparam state_t S_RESPOND = 3'd4;

endpackage

// File: rtl/l2_cache_controller_tag_array.sv
// Tag/valid store for the direct-mapped L2: combinational lookup, synchronous
// write on refill, whole-array invalidate on flush.
module l2_cache_controller_tag_array #(
  parameter int INDEX_W = 8,
  parameter int TAG_W   = 52
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INDEX_W-1:0] index,
  input  logic [TAG_W-1:0]   tag,
  input  logic               write,
  input  logic               flush,
  output logic               hit
);

  localparam int SETS = 1 << INDEX_W;

  logic [SETS-1:0]  valid;
  logic [TAG_W-1:0] tag_mem [SETS];

  assign hit = valid[index] && (tag_mem[index] == tag);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      valid <= '0;
    end else if (write) begin
      valid[index] <= 1'b1;
    end
  end

  // NOTE: the tag RAM has no reset; a stale tag is harmless while its valid bit is 0.
  always_ff @(posedge clk) begin
    if (write) begin
      tag_mem[index] <= tag;
    end
  end

endmodule

// File: rtl/l2_cache_controller.sv
// Direct-mapped, read-only L2 controller serving L1-I line misses.
// Optional feature macro: L2_PERF_CNT_EN adds saturating hit_cnt/miss_cnt outputs.
module l2_cache_controller
  import l2_cache_controller_pkg::*;
#(
  parameter int L1_TAG_W   = L1_TAG_W_DEF,
  parameter int L1_INDEX_W = L1_INDEX_W_DEF,
  parameter int L2_INDEX_W = L2_INDEX_W_DEF,
  parameter int L2_TAG_W   = L1_TAG_W + L1_INDEX_W - L2_INDEX_W
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         read_l1_l2,
  input  logic [L1_TAG_W-1:0]          tag_l1_l2,
  input  logic [L1_INDEX_W-1:0]        index_l1_l2,
  input  logic                         flush,
  output logic                         ready_l2_l1,
  output logic                         read_l2_mem,
  output logic [L1_TAG_W+L1_INDEX_W-1:0] addr_l2_mem,
  input  logic                         ready_mem_l2,
  output logic                         refill,
  output logic [L2_INDEX_W-1:0]        l2_index,
`ifdef L2_PERF_CNT_EN
  output logic [31:0]                  hit_cnt,
  output logic [31:0]                  miss_cnt,
`endif
  output logic                         stall_l2
);

  localparam int LINE_W = L1_TAG_W + L1_INDEX_W;

  state_t            state, state_nxt;
  logic [LINE_W-1:0] req_line;
  logic              ready_q;
  logic              hit;
  logic              accept;

  // Accepting only when ready was low last cycle keeps a request that L1 is
  // still dropping from being served twice; a concurrent flush takes priority.
  assign accept = (state == S_IDLE) && read_l1_l2 && !ready_q && !flush;

  l2_cache_controller_tag_array #(
    .INDEX_W (L2_INDEX_W),
    .TAG_W   (L2_TAG_W)
  ) u_tag_array (
    .clk   (clk),
    .reset (reset),
    .index (req_line[L2_INDEX_W-1:0]),
    .tag   (req_line[LINE_W-1:L2_INDEX_W]),
    .write (state == S_REFILL),
    .flush ((state == S_IDLE) && flush),
    .hit   (hit)
  );

  // NOTE: default assignment first so no path through always_comb infers a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:    if (accept) state_nxt = S_COMPARE;
      S_COMPARE: state_nxt = hit ? S_RESPOND : S_MEM_REQ;
      S_MEM_REQ: if (ready_mem_l2) state_nxt = S_REFILL;
      S_REFILL:  state_nxt = S_RESPOND;
      S_RESPOND: state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      req_line <= '0;
      ready_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      ready_q <= ready_l2_l1;
      if (accept) begin
        req_line <= {tag_l1_l2, index_l1_l2};
      end
    end
  end

  assign ready_l2_l1 = (state == S_RESPOND);
  assign read_l2_mem = (state == S_MEM_REQ);
  assign refill      = (state == S_REFILL);
  assign stall_l2    = (state != S_IDLE);
  assign addr_l2_mem = req_line;
  assign l2_index    = req_line[L2_INDEX_W-1:0];

`ifdef L2_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (state == S_COMPARE) begin
      if (hit && hit_cnt != 32'hFFFF_FFFF) begin
        hit_cnt <= hit_cnt + 32'd1;
      end
      if (!hit && miss_cnt != 32'hFFFF_FFFF) begin
        miss_cnt <= miss_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
